// File: rtl/noc_pkg.sv
// noc_pkg: packet layout and port indices shared by the mesh router blocks
package noc_pkg;
  localparam int WIDTH    = 33;
  localparam int TYPE_BIT = 32;
  localparam int DST_HI   = 31;
  localparam int DST_LO   = 28;
  localparam int SRC_HI   = 27;
  localparam int SRC_LO   = 24;
  localparam int DATA_HI  = 23;
  localparam int DATA_LO  = 0;
  localparam int N_PORTS  = 5;
  localparam int PTR_W    = $clog2(N_PORTS);
  typedef enum logic [PTR_W-1:0] {P_N, P_E, P_S, P_W, P_PE} port_e;
endpackage

// File: rtl/out_port_arbiter_if.sv
// out_port_arbiter_if: requester-side and link-side signals of one output port
interface out_port_arbiter_if;
  import noc_pkg::*;
  logic [N_PORTS-1:0]       req_valid;
  logic [N_PORTS*WIDTH-1:0] req_data;
  logic [N_PORTS-1:0]       req_ready;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_data;
  logic                     out_ready;
  logic [PTR_W-1:0]         grant_id;
  logic [PTR_W-1:0]         rr_ptr;
  modport slave (input req_valid, req_data, out_ready,
                 output req_ready, out_valid, out_data, grant_id, rr_ptr);
  modport master (output req_valid, req_data, out_ready,
                  input req_ready, out_valid, out_data, grant_id, rr_ptr);
endinterface

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first valid index scanning upward from ptr, wrapping modulo N
module rr_priority_pick #(
  parameter int N  = 5,
  parameter int PW = 3
) (
  input  logic [N-1:0]  i_valid,
  input  logic [PW-1:0] i_ptr,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);
  logic [PW:0] w_sum, w_idx;
  always_comb begin
    o_idx = '0;
    o_any = |i_valid;
    w_sum = '0;
    w_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + (PW+1)'(k);
      w_idx = (w_sum >= (PW+1)'(N)) ? w_sum - (PW+1)'(N) : w_sum;
      if (i_valid[w_idx]) o_idx = w_idx[PW-1:0];
    end
  end
endmodule

// File: rtl/out_port_arbiter.sv
// out_port_arbiter: round-robin N/E/S/W/PE arbiter feeding a one-entry registered output stage
module out_port_arbiter
  import noc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  out_port_arbiter_if.slave bus
);
  logic [PTR_W-1:0] w_win, r_ptr, r_gid;
  logic             w_any, w_accept, w_take, r_valid;
  logic [WIDTH-1:0] r_data;
  rr_priority_pick #(.N(N_PORTS), .PW(PTR_W)) u_pick (
    .i_valid(bus.req_valid),
    .i_ptr  (r_ptr),
    .o_idx  (w_win),
    .o_any  (w_any)
  );
  assign w_accept      = !r_valid || bus.out_ready;
  assign w_take        = w_accept && w_any;
  assign bus.req_ready = (rst_n && w_take) ? (N_PORTS)'(1) << w_win : '0;
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.grant_id  = r_gid;
  assign bus.rr_ptr    = r_ptr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_gid   <= '0;
      r_ptr   <= '0;
    end else if (w_take) begin
      r_valid <= 1'b1;
      r_data  <= bus.req_data[int'(w_win)*WIDTH +: WIDTH];
      r_gid   <= w_win;
      r_ptr   <= (w_win == PTR_W'(N_PORTS - 1)) ? '0 : w_win + 1'b1;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end
  a_onehot: assert property (@(posedge clk) $onehot0(bus.req_ready));
  a_stable: assert property (@(posedge clk) disable iff (!rst_n)
                             r_valid && !bus.out_ready |=> $stable(r_data));
  a_ptr:    assert property (@(posedge clk) r_ptr < PTR_W'(N_PORTS));
endmodule

// File: tb/tb_out_port_arbiter.sv
// tb_out_port_arbiter: directed vectors with hand-computed expectations for out_port_arbiter
module tb_out_port_arbiter;
  import noc_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  out_port_arbiter_if bus ();
  out_port_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [WIDTH-1:0] pkt(input int i);
    return {1'b0, 4'h0, 4'(i), 24'hABC000 + 24'(i)};
  endfunction
  task automatic load_all();
    for (int i = 0; i < N_PORTS; i++) bus.req_data[i*WIDTH +: WIDTH] = pkt(i);
  endtask
  task automatic grant(input string tag, input int g, input int p);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_gid"}, 64'(bus.grant_id), 64'(g));
    chk({tag, "_ptr"}, 64'(bus.rr_ptr), 64'(p));
    chk({tag, "_src"}, 64'(bus.out_data[SRC_HI:SRC_LO]), 64'(g));
  endtask
  int exp_g [8] = '{3, 4, 0, 1, 2, 3, 4, 0};
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("rst_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_ptr", 64'(bus.rr_ptr), 64'd0);
      chk("rst_data", 64'(bus.out_data), 64'd0);
      step();
    end
    rst_n = 1'b1;
    step();
    step();
    chk("idle_valid", 64'(bus.out_valid), 64'd0);
    chk("idle_ready", 64'(bus.req_ready), 64'd0);
    chk("idle_ptr", 64'(bus.rr_ptr), 64'd0);
    bus.req_data[2*WIDTH +: WIDTH] = 33'h1_25D2E5B8;
    bus.req_valid = 5'b00100;
    #1;
    chk("single_ready", 64'(bus.req_ready), 64'h04);
    step();
    chk("single_valid", 64'(bus.out_valid), 64'd1);
    chk("single_data", 64'(bus.out_data), 64'h1_25D2E5B8);
    chk("single_gid", 64'(bus.grant_id), 64'd2);
    chk("single_ptr", 64'(bus.rr_ptr), 64'd3);
    bus.req_valid = '0;
    step();
    chk("drain_valid", 64'(bus.out_valid), 64'd0);
    chk("drain_data", 64'(bus.out_data), 64'h1_25D2E5B8);
    chk("drain_gid", 64'(bus.grant_id), 64'd2);
    chk("drain_ptr", 64'(bus.rr_ptr), 64'd3);
    load_all();
    bus.req_valid = 5'b11111;
    for (int k = 0; k < 8; k++) begin
      step();
      grant("rr", exp_g[k], (exp_g[k] + 1) % N_PORTS);
      chk("rr_data", 64'(bus.out_data), 64'(pkt(exp_g[k])));
    end
    bus.req_valid = 5'b10001;
    #1;
    chk("skip_ready_pe", 64'(bus.req_ready), 64'h10);
    step();
    grant("skip_pe", 4, 0);
    chk("skip_ready_n", 64'(bus.req_ready), 64'h01);
    step();
    grant("skip_n", 0, 1);
    bus.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp_ready", 64'(bus.req_ready), 64'd0);
      step();
      grant("bp_hold", 0, 1);
      chk("bp_data", 64'(bus.out_data), 64'(pkt(0)));
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_rel_ready", 64'(bus.req_ready), 64'h10);
    step();
    grant("bp_rel_pe", 4, 0);
    step();
    grant("bp_rel_n", 0, 1);
    bus.req_valid = '0;
    step();
    chk("bp_end_valid", 64'(bus.out_valid), 64'd0);
    bus.req_valid = 5'b11111;
    step();
    grant("pre_rst", 1, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_ptr", 64'(bus.rr_ptr), 64'd0);
    chk("arst_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 64'(bus.req_ready), 64'h01);
    step();
    grant("post_rst", 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
